// File: rtl/pc_sequencer_if.sv
// Control-side bundle for the PC sequencer: the mode/target request in one
// direction, and the PC and stack status flags in the other.
interface pc_sequencer_if #(
  parameter int AW        = 8,
  parameter int STK_DEPTH = 4
);
  localparam int DW = $clog2(STK_DEPTH + 1);

  logic          en;
  logic [1:0]    sel;
  logic [AW-1:0] target;
  logic          err_clr;
  logic [AW-1:0] pc;
  logic          stk_full;
  logic          stk_empty;
  logic          err;
  logic [DW-1:0] depth;

  modport master (
    output en, sel, target, err_clr,
    input  pc, stk_full, stk_empty, err, depth
  );

  modport slave (
    input  en, sel, target, err_clr,
    output pc, stk_full, stk_empty, err, depth
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with increment/branch/call/return modes, stall,
// and a return-address stack whose top entry always sits in slot 0.
module pc_sequencer #(
  parameter int            AW        = 8,
  parameter int            STK_DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);
  localparam int DW = $clog2(STK_DEPTH + 1);

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_BRA = 2'b01;
  localparam logic [1:0] SEL_CAL = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  logic [AW-1:0] pc_p0;
  logic [DW-1:0] occ_p0;
  logic          err_p0;
  logic [AW-1:0] stk_p0 [STK_DEPTH];

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_nxt;
  logic [DW-1:0] occ_nxt;
  logic          push;
  logic          pop;
  logic          set_err;
  logic          full;
  logic          empty;

  assign pc_inc = pc_p0 + AW'(1);
  assign full   = (occ_p0 == DW'(STK_DEPTH));
  assign empty  = (occ_p0 == '0);

  always_comb begin
    pc_nxt  = pc_p0;
    occ_nxt = occ_p0;
    push    = 1'b0;
    pop     = 1'b0;
    set_err = 1'b0;
    if (bus.en) begin
      unique case (bus.sel)
        SEL_INC: pc_nxt = pc_inc;
        SEL_BRA: pc_nxt = bus.target;
        SEL_CAL: begin
          // Overflowing call still jumps; only the return address is lost.
          pc_nxt = bus.target;
          if (full) begin
            set_err = 1'b1;
          end else begin
            push    = 1'b1;
            occ_nxt = occ_p0 + DW'(1);
          end
        end
        SEL_RET: begin
          if (empty) begin
            pc_nxt  = pc_inc;
            set_err = 1'b1;
          end else begin
            pc_nxt  = stk_p0[0];
            pop     = 1'b1;
            occ_nxt = occ_p0 - DW'(1);
          end
        end
        default: pc_nxt = pc_p0;
      endcase
    end
  end

  // ---- stage p0: architectural state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0  <= RESET_VEC;
      occ_p0 <= '0;
      err_p0 <= 1'b0;
    end else begin
      pc_p0  <= pc_nxt;
      occ_p0 <= occ_nxt;
      if (set_err) begin
        err_p0 <= 1'b1;
      end else if (bus.err_clr) begin
        err_p0 <= 1'b0;
      end
    end
  end

  // Stack contents carry no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      stk_p0[0] <= pc_inc;
      for (int i = 1; i < STK_DEPTH; i++) begin
        stk_p0[i] <= stk_p0[i-1];
      end
    end else if (pop) begin
      for (int i = 0; i < STK_DEPTH - 1; i++) begin
        stk_p0[i] <= stk_p0[i+1];
      end
    end
  end

  assign bus.pc        = pc_p0;
  assign bus.depth     = occ_p0;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.err       = err_p0;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through the main scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_pc_sequencer;
  localparam int            AW        = 8;
  localparam int            STK_DEPTH = 4;
  localparam logic [AW-1:0] RESET_VEC = 8'h00;
  localparam int            DW        = $clog2(STK_DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;

  pc_sequencer_if #(.AW(AW), .STK_DEPTH(STK_DEPTH)) bus ();

  pc_sequencer #(.AW(AW), .STK_DEPTH(STK_DEPTH), .RESET_VEC(RESET_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] m_pc  = RESET_VEC;
  logic          m_err = 1'b0;
  logic [AW-1:0] m_stk [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic [1:0] s,
                       input logic [AW-1:0] t, input logic c);
    logic set;
    set = 1'b0;
    if (r) begin
      m_pc  = RESET_VEC;
      m_err = 1'b0;
      m_stk.delete();
    end else begin
      if (e) begin
        case (s)
          2'd0: m_pc = m_pc + 8'd1;
          2'd1: m_pc = t;
          2'd2: begin
            if (m_stk.size() == STK_DEPTH) set = 1'b1;
            else m_stk.push_front(m_pc + 8'd1);
            m_pc = t;
          end
          default: begin
            if (m_stk.size() == 0) begin
              m_pc = m_pc + 8'd1;
              set  = 1'b1;
            end else begin
              m_pc = m_stk.pop_front();
            end
          end
        endcase
      end
      if (set) m_err = 1'b1;
      else if (c) m_err = 1'b0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare #1 after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] s,
                      input logic [AW-1:0] t, input logic c);
    rst         = r;
    bus.en      = e;
    bus.sel     = s;
    bus.target  = t;
    bus.err_clr = c;
    @(posedge clk);
    model(r, e, s, t, c);
    #1;
    chk("pc",    32'(bus.pc),        32'(m_pc));
    chk("depth", 32'(bus.depth),     32'(m_stk.size()));
    chk("full",  32'(bus.stk_full),  32'(m_stk.size() == STK_DEPTH));
    chk("empty", 32'(bus.stk_empty), 32'(m_stk.size() == 0));
    chk("err",   32'(bus.err),       32'(m_err));
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.sel = 2'b00; bus.target = '0; bus.err_clr = 1'b0;

    // reset then increment with wrap
    step(1, 0, 2'd0, 8'h00, 0);
    chk("rst_pc", 32'(bus.pc), 32'h00);
    chk("rst_empty", 32'(bus.stk_empty), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 2'd0, 8'h00, 0);
      chk("inc_pc", 32'(bus.pc), 32'(i));
    end
    step(0, 1, 2'd1, 8'hFF, 0);
    step(0, 1, 2'd0, 8'h00, 0);
    chk("wrap_pc", 32'(bus.pc), 32'h00);

    // branch and stall
    step(0, 1, 2'd1, 8'h10, 0);
    step(0, 1, 2'd1, 8'h80, 0);
    chk("bra_pc", 32'(bus.pc), 32'h80);
    step(0, 0, 2'd0, 8'h00, 0);
    step(0, 0, 2'd0, 8'h00, 0);
    chk("stall_pc", 32'(bus.pc), 32'h80);

    // nested call/return
    step(0, 1, 2'd1, 8'h05, 0);
    step(0, 1, 2'd2, 8'h40, 0);
    step(0, 1, 2'd2, 8'h60, 0);
    chk("nest_depth", 32'(bus.depth), 32'd2);
    step(0, 1, 2'd3, 8'h00, 0);
    chk("ret1_pc", 32'(bus.pc), 32'h41);
    step(0, 1, 2'd3, 8'h00, 0);
    chk("ret2_pc", 32'(bus.pc), 32'h06);

    // overflow then LIFO unwind
    step(0, 1, 2'd1, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 2'd2, 8'h20, 0);
    chk("ovf_full", 32'(bus.stk_full), 32'd1);
    chk("ovf_err", 32'(bus.err), 32'd1);
    chk("ovf_pc", 32'(bus.pc), 32'h20);
    step(0, 1, 2'd3, 8'h00, 0); chk("unw1", 32'(bus.pc), 32'h21);
    step(0, 1, 2'd3, 8'h00, 0); chk("unw2", 32'(bus.pc), 32'h21);
    step(0, 1, 2'd3, 8'h00, 0); chk("unw3", 32'(bus.pc), 32'h21);
    step(0, 1, 2'd3, 8'h00, 0); chk("unw4", 32'(bus.pc), 32'h01);

    // underflow, clear, and set-wins
    step(0, 1, 2'd0, 8'h00, 1);
    step(0, 1, 2'd1, 8'h33, 0);
    step(0, 1, 2'd3, 8'h00, 0);
    chk("udf_pc", 32'(bus.pc), 32'h34);
    chk("udf_err", 32'(bus.err), 32'd1);
    step(0, 1, 2'd0, 8'h00, 1);
    chk("clr_err", 32'(bus.err), 32'd0);
    step(0, 1, 2'd3, 8'h00, 1);
    chk("setwins_err", 32'(bus.err), 32'd1);
    step(0, 0, 2'd3, 8'h00, 1);
    chk("stall_clr_err", 32'(bus.err), 32'd0);

    // reset mid-sequence
    step(0, 1, 2'd2, 8'h50, 0);
    step(0, 1, 2'd2, 8'h70, 0);
    step(1, 1, 2'd2, 8'h90, 0);
    chk("midrst_pc", 32'(bus.pc), 32'(RESET_VEC));
    chk("midrst_depth", 32'(bus.depth), 32'd0);
    step(0, 1, 2'd3, 8'h00, 0);
    chk("midrst_udf", 32'(bus.err), 32'd1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step(logic'($urandom_range(63) == 0),
           logic'($urandom_range(7) != 0),
           2'($urandom_range(3)),
           8'($urandom),
           logic'($urandom_range(7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
